link_credit_rx: RTL and testbench
=================================

// Module: link_credit_rx
// PURPOSE
//  Receive end of a point-to-point router link whose forward path is a plain direct wire.
//  Captures flits into a DEPTH-entry FIFO, presents them to the local router input port
//  with valid/ready, and returns one credit pulse per freed slot on the reverse wire.
//  After reset it issues the initial credit grant; the transmitter comes out of reset holding zero credits.
// PARAMETERS
//  DATA_W  32  flit width in bits
//  DEPTH   4   FIFO entries = initial credits; power of two, >= 2
//  CNT_W   $clog2(DEPTH+1)  derived width of fill_level; not overridden
// PORTS
//  clk           in   1       single clock
//  rst_n         in   1       synchronous reset, active-low
//  in_valid      in   1       flit present on in_data this cycle (no backpressure on link)
//  in_data       in   DATA_W  incoming flit
//  credit_out    out  1       one-cycle pulse = one slot returned to transmitter
//  out_valid     out  1       FIFO head valid toward router
//  out_data      out  DATA_W  FIFO head (first-word fall-through)
//  out_ready     in   1       router consumes head when out_valid & out_ready
//  fill_level    out  CNT_W   entries currently held, 0..DEPTH
//  overflow_err  out  1       sticky: flit arrived with no free slot, or during INIT
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=INIT, init_cnt=0, wr/rd ptr=0, fill_level=0,
//   out_valid=0, credit_out=0, overflow_err=0. out_data is don't-care while out_valid=0.
//  FSM INIT: credit_out=1 on each of the first DEPTH cycles after rst_n rises; init_cnt counts to DEPTH,
//   then -> RUN. in_valid during INIT: flit dropped, overflow_err<=1.
//  FSM RUN: persistent until reset. No other states.
//  Push: in_valid in RUN. Pop: out_valid & out_ready.
//  Latency: push at cycle t -> out_valid/out_data/fill_level reflect it at t+1 (FIFO previously empty).
//   Pop at cycle t -> credit_out=1 at t+1, exactly one pulse per pop; no pulse without a pop.
//  Full (fill_level=DEPTH): push with same-cycle pop accepted, fill_level unchanged, credit issued.
//   Push without pop: flit dropped, contents/pointers unchanged, overflow_err<=1.
//  Empty: out_valid=0; out_ready ignored; simultaneous push+pop impossible (no bypass path).
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH; fill_level = registered count, +1/-1/0.
//  overflow_err cleared only by reset. Reset mid-operation discards all flits, restarts INIT grant.
//  All outputs registered; no combinational path in_* -> out_* or out_ready -> credit_out.
// STRUCTURE
//  link_pkg: LINK_DATA_W, LINK_DEPTH defaults; typedef enum logic {RX_INIT, RX_RUN} rx_state_t.
//  Sub-module link_rx_fifo (storage, pointers, count, FWFT head); top holds FSM, credit and error logic.
// TESTING
//  1 Reset, DEPTH=4, in_valid=0 -> credit_out=1 on cycles 1-4 after rst_n rises, 0 after; fill_level=0.
//  2 RUN, out_ready=0, push 0xA0..0xA3 -> fill_level=4, no credit_out; 5th push 0xA4 -> overflow_err=1, fill_level=4.
//  3 From full, out_ready=1 for 4 cycles -> out_data 0xA0,0xA1,0xA2,0xA3 in order; 4 credit pulses each 1 cycle after pop.
//  4 Full, push 0xB0 with pop same cycle -> fill_level stays 4, overflow_err stays 0, credit_out=1 next cycle, 0xB0 read last.
//  5 Stream 10 flits with out_ready toggling 1010.. -> wrap-around, order preserved, credits total = pops.
//  6 rst_n=0 with fill_level=3 -> next cycle fill_level=0, out_valid=0, overflow_err=0, INIT grants 4 credits again.

Source files
------------

// File: rtl/link_pkg.sv
// Shared defaults and state encoding for the router link receive path.
package link_pkg;

  localparam int unsigned LINK_DATA_W = 32;
  localparam int unsigned LINK_DEPTH  = 4;

  typedef enum logic {
    RX_INIT = 1'b0,
    RX_RUN  = 1'b1
  } rx_state_t;

endpackage : link_pkg

// File: rtl/link_rx_fifo.sv
// Receive FIFO with first-word fall-through head, all outputs registered.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   wr_en_i      write wr_data_i this cycle (caller guarantees a free slot or a same-cycle read)
//   wr_data_i    flit to store
//   rd_en_i      consume head this cycle (caller guarantees rd_valid_o)
//   rd_valid_o   head present
//   rd_data_o    head flit
//   count_o      entries held, 0..DEPTH
module link_rx_fifo
  import link_pkg::*;
#(
  parameter int unsigned DATA_W = LINK_DATA_W,
  parameter int unsigned DEPTH  = LINK_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic                         rd_en_i,
  output logic                         rd_valid_o,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] head_q, head_d;

  // Next pointers, count and registered head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // The incoming flit becomes the head when it lands in the slot the read pointer moves to.
    head_d  = (wr_en_i && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = head_q;
  assign count_o    = count_q;

endmodule : link_rx_fifo

// File: rtl/link_credit_rx.sv
// Receive end of a credit-based router link: buffers flits, presents them
// valid/ready to the router, grants DEPTH initial credits after reset and
// returns one credit pulse per consumed flit.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       flit on in_data this cycle (link has no backpressure)
//   in_data        incoming flit
//   credit_out     one-cycle pulse per slot returned to the transmitter
//   out_valid      FIFO head valid
//   out_data       FIFO head
//   out_ready      router consumes head when out_valid & out_ready
//   fill_level     entries held
//   overflow_err   sticky: flit arrived with no free slot or during the initial grant
module link_credit_rx
  import link_pkg::*;
#(
  parameter int unsigned DATA_W = LINK_DATA_W,
  parameter int unsigned DEPTH  = LINK_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        credit_out,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  fill_level,
  output logic                        overflow_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rx_state_t        state_q;
  logic [CNT_W-1:0] init_cnt_q;
  logic             credit_q;
  logic             overflow_q;

  logic             pop;
  logic             push;
  logic             full;
  logic             run;

  assign run  = (state_q == RX_RUN);
  assign full = (fill_level == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign push = run & in_valid & (~full | pop);

  // Initial credit grant, credit return and overflow tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_INIT;
      init_cnt_q <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        RX_INIT: begin
          credit_q   <= 1'b1;
          init_cnt_q <= init_cnt_q + CNT_W'(1);
          if (init_cnt_q == CNT_W'(DEPTH - 1)) state_q <= RX_RUN;
          if (in_valid) overflow_q <= 1'b1;
        end
        RX_RUN: begin
          credit_q <= pop;
          if (in_valid && full && !pop) overflow_q <= 1'b1;
        end
      endcase
    end
  end

  link_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (push),
    .wr_data_i  (in_data),
    .rd_en_i    (pop),
    .rd_valid_o (out_valid),
    .rd_data_o  (out_data),
    .count_o    (fill_level)
  );

  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

endmodule : link_credit_rx

// File: tb/tb_link_credit_rx.sv
// Directed bench for link_credit_rx (DATA_W=32, DEPTH=4).
module tb_link_credit_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        credit_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  fill_level;
  logic        overflow_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  link_credit_rx #(.DATA_W(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .credit_out   (credit_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .fill_level   (fill_level),
    .overflow_err (overflow_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_list [4];
    logic [31:0] model [$];
    logic        pop_pred;
    int          sent;
    int          pops;
    int          credits;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_credit", 32'(credit_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);

    // Initial grant: four pulses, then quiet
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("init_credit", 32'(credit_out), 32'd1);
      chk("init_fill", 32'(fill_level), 32'd0);
    end
    tick();
    chk("init_done_credit", 32'(credit_out), 32'd0);

    // Fill to DEPTH with no consumer
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(i);
      tick();
      chk("fill_level", 32'(fill_level), 32'(i + 1));
      chk("fill_credit", 32'(credit_out), 32'd0);
      chk("fill_valid", 32'(out_valid), 32'd1);
      chk("fill_head", out_data, 32'hA0);
    end

    // Full: push with same-cycle pop is accepted
    in_data = 32'hB0; out_ready = 1'b1;
    chk("full_head", out_data, 32'hA0);
    tick();
    chk("pp_fill", 32'(fill_level), 32'd4);
    chk("pp_credit", 32'(credit_out), 32'd1);
    chk("pp_ovf", 32'(overflow_err), 32'd0);
    chk("pp_head", out_data, 32'hA1);

    // Full: push without pop is dropped and flagged
    in_data = 32'hA4; out_ready = 1'b0;
    tick();
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    chk("ovf_fill", 32'(fill_level), 32'd4);
    chk("ovf_credit", 32'(credit_out), 32'd0);
    chk("ovf_head", out_data, 32'hA1);

    // Drain: order preserved, one credit per pop, B0 last
    in_valid = 1'b0; out_ready = 1'b1;
    exp_list[0] = 32'hA1; exp_list[1] = 32'hA2; exp_list[2] = 32'hA3; exp_list[3] = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", out_data, exp_list[i]);
      tick();
      chk("drain_credit", 32'(credit_out), 32'd1);
      chk("drain_fill", 32'(fill_level), 32'(3 - i));
    end
    chk("drain_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty_ready_credit", 32'(credit_out), 32'd0);
    chk("empty_ready_fill", 32'(fill_level), 32'd0);

    // Stream ten flits with out_ready toggling; pointers wrap
    sent = 0; pops = 0; credits = 0;
    for (int c = 0; c < 60 && (sent < 10 || model.size() > 0); c++) begin
      out_ready = (c % 2 == 0);
      pop_pred  = out_ready && (model.size() > 0);
      in_valid  = (sent < 10) && (model.size() < 4 || pop_pred);
      in_data   = 32'hC0 + 32'(sent);
      chk("s_valid", 32'(out_valid), 32'(model.size() > 0));
      if (model.size() > 0) chk("s_head", out_data, model[0]);
      if (pop_pred) begin
        void'(model.pop_front());
        pops++;
      end
      if (in_valid) begin
        model.push_back(in_data);
        sent++;
      end
      tick();
      if (credit_out) credits++;
      chk("s_credit", 32'(credit_out), 32'(pop_pred));
      chk("s_fill", 32'(fill_level), 32'(model.size()));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("s_sent", 32'(sent), 32'd10);
    chk("s_pops", 32'(pops), 32'd10);
    chk("s_credits", 32'(credits), 32'(pops));
    chk("s_ovf_sticky", 32'(overflow_err), 32'd1);

    // Reset mid-operation with three entries held
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hD0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_fill", 32'(fill_level), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
    chk("mid_rst_credit", 32'(credit_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 1);
      in_data  = 32'hEE;
      tick();
      chk("regrant_credit", 32'(credit_out), 32'd1);
      chk("regrant_fill", 32'(fill_level), 32'd0);
    end
    in_valid = 1'b0;
    chk("init_push_ovf", 32'(overflow_err), 32'd1);
    tick();
    chk("regrant_done", 32'(credit_out), 32'd0);

    // Normal push after the second grant
    in_valid = 1'b1; in_data = 32'hE0;
    tick();
    in_valid = 1'b0;
    chk("post_push_valid", 32'(out_valid), 32'd1);
    chk("post_push_head", out_data, 32'hE0);
    chk("post_push_fill", 32'(fill_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_link_credit_rx
